// File: rtl/lcm_add.sv
// Iterative LCM by repeated addition with a start/busy/done handshake.
// Define LCM_ADD_ITER_COUNT_EN to add the iters_o addition-step counter port.
module lcm_add #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] lcm_o,
`ifdef LCM_ADD_ITER_COUNT_EN
    output logic [WIDTH-1:0] iters_o,
`endif
    output logic             ovf_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
    logic [WIDTH-1:0] ma_q, ma_d, mb_q, mb_d;
    logic [WIDTH-1:0] lcm_q, lcm_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   sumA, sumB;
`ifdef LCM_ADD_ITER_COUNT_EN
    logic [WIDTH-1:0] iters_q, iters_d;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The extra top bit of each sum is the carry that flags overflow.
    assign sumA = {1'b0, ma_q} + {1'b0, ra_q};
    assign sumB = {1'b0, mb_q} + {1'b0, rb_q};

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        lcm_d   = lcm_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
`ifdef LCM_ADD_ITER_COUNT_EN
        iters_d = iters_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ra_d    = a_i;
                    rb_d    = b_i;
                    ma_d    = a_i;
                    mb_d    = b_i;
                    state_d = RUN;
`ifdef LCM_ADD_ITER_COUNT_EN
                    iters_d = '0;
`endif
                end
            end
            RUN: begin
                if (ra_q == '0 || rb_q == '0) begin
                    lcm_d   = '0;
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (ma_q == mb_q) begin
                    lcm_d   = ma_q;
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (ma_q < mb_q) begin
`ifdef LCM_ADD_ITER_COUNT_EN
                    iters_d = iters_q + WIDTH'(1);
`endif
                    if (sumA[WIDTH]) begin
                        lcm_d   = '0;
                        ovf_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ma_d = sumA[WIDTH-1:0];
                    end
                end else begin
`ifdef LCM_ADD_ITER_COUNT_EN
                    iters_d = iters_q + WIDTH'(1);
`endif
                    if (sumB[WIDTH]) begin
                        lcm_d   = '0;
                        ovf_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        mb_d = sumB[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ra_q    <= '0;
            rb_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            lcm_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef LCM_ADD_ITER_COUNT_EN
            iters_q <= '0;
`endif
        end else begin
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            lcm_q   <= lcm_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
`ifdef LCM_ADD_ITER_COUNT_EN
            iters_q <= iters_d;
`endif
        end
    end

    always_comb begin
        busy_o = (state_q == RUN);
        done_o = done_q;
        lcm_o  = lcm_q;
        ovf_o  = ovf_q;
`ifdef LCM_ADD_ITER_COUNT_EN
        iters_o = iters_q;
`endif
    end

endmodule

// File: tb/tb_lcm_add.sv
// Self-checking bench for lcm_add: a directed vector table plus handshake corner sequences.
// Honours LCM_ADD_ITER_COUNT_EN by also checking the iters_o counter.
module tb_lcm_add;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, ovf;
    logic [W-1:0] lcm;
`ifdef LCM_ADD_ITER_COUNT_EN
    logic [W-1:0] iters;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expLcm;
        logic         expOvf;
        int           expLat;
        int           expIters;
    } vec_t;

    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    lcm_add #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .lcm_o   (lcm),
`ifdef LCM_ADD_ITER_COUNT_EN
        .iters_o (iters),
`endif
        .ovf_o   (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issues one operand pair and waits (bounded) for done; optionally pulses
    // start with a=3,b=5 at loop step glitchAt while the unit is busy.
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input int glitchAt, output int lat, output int busyCnt);
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = '0;
        b = '0;
        lat = 0;
        busyCnt = 0;
        for (int k = 1; k <= 2000; k++) begin
            if (busy) busyCnt++;
            start = (k == glitchAt);
            if (k == glitchAt) begin
                a = 3;
                b = 5;
            end
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        if (lat == 0) checkOutput("doneTimeout", 64'd0, 64'd1);
    endtask

    task automatic runVector(input vec_t v, input int glitchAt, input string tag);
        int lat, busyCnt;
        applyStimulus(v.a, v.b, glitchAt, lat, busyCnt);
        checkOutput({tag, ".latency"}, 64'(lat), 64'(v.expLat));
        checkOutput({tag, ".busyCycles"}, 64'(busyCnt), 64'(v.expLat));
        checkOutput({tag, ".busyAtDone"}, 64'(busy), 64'd0);
        checkOutput({tag, ".lcm"}, 64'(lcm), 64'(v.expLcm));
        checkOutput({tag, ".ovf"}, 64'(ovf), 64'(v.expOvf));
`ifdef LCM_ADD_ITER_COUNT_EN
        checkOutput({tag, ".iters"}, 64'(iters), 64'(v.expIters));
`endif
        @(negedge clk);
        checkOutput({tag, ".donePulse"}, 64'(done), 64'd0);
        checkOutput({tag, ".lcmHeld"}, 64'(lcm), 64'(v.expLcm));
    endtask

    initial begin
        int doneSeen;
        vecs[0] = '{32'd4, 32'd6, 32'd12, 1'b0, 4, 3};
        vecs[1] = '{32'd7, 32'd7, 32'd7, 1'b0, 1, 0};
        vecs[2] = '{32'd0, 32'd5, 32'd0, 1'b0, 1, 0};
        vecs[3] = '{32'd9, 32'd4, 32'd36, 1'b0, 12, 11};
        vecs[4] = '{32'd4, 32'd9, 32'd36, 1'b0, 12, 11};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 1'b1, 1, 1};
        vecs[6] = '{32'd5, 32'd3, 32'd15, 1'b0, 7, 6};
        vecs[7] = '{32'd6, 32'd0, 32'd0, 1'b0, 1, 0};
        vecs[8] = '{32'd1, 32'd255, 32'd255, 1'b0, 255, 254};

        rst = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.lcm", 64'(lcm), 64'd0);
        checkOutput("reset.ovf", 64'(ovf), 64'd0);
`ifdef LCM_ADD_ITER_COUNT_EN
        checkOutput("reset.iters", 64'(iters), 64'd0);
`endif
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            runVector(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // start pulsed mid-RUN must not disturb the 9,4 operation
        runVector(vecs[3], 3, "midRunStart");

        // start held high through done: 7,7 accepted in the done cycle
        @(negedge clk);
        a = 4;
        b = 6;
        start = 1'b1;
        @(negedge clk);
        a = 7;
        b = 7;
        doneSeen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                doneSeen = k;
                break;
            end
        end
        checkOutput("b2b.firstLatency", 64'(doneSeen), 64'd4);
        checkOutput("b2b.firstLcm", 64'(lcm), 64'd12);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b.secondBusy", 64'(busy), 64'd1);
        checkOutput("b2b.secondNoDone", 64'(done), 64'd0);
        @(negedge clk);
        checkOutput("b2b.secondDone", 64'(done), 64'd1);
        checkOutput("b2b.secondLcm", 64'(lcm), 64'd7);

        // reset mid-RUN discards the operation and clears the result
        @(negedge clk);
        a = 9;
        b = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midReset.busyBefore", 64'(busy), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midReset.busy", 64'(busy), 64'd0);
        checkOutput("midReset.done", 64'(done), 64'd0);
        checkOutput("midReset.lcm", 64'(lcm), 64'd0);
        checkOutput("midReset.ovf", 64'(ovf), 64'd0);
        rst = 1'b1;
        doneSeen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        checkOutput("midReset.quiet", 64'(doneSeen), 64'd0);

        runVector(vecs[0], 0, "afterReset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
